vga_framebuffer: RTL and testbench

- Pixel store directly upstream of the VGA timing/output stage.
- Game logic writes coarse cells through a valid/ready port into a small write FIFO.
- The VGA stage reads the colour of the current screen pixel with a fixed 2-cycle latency.
- A clear-screen FSM blanks the whole buffer on request; single clock domain.

---
 rtl/vga_framebuffer.sv | 193 +++++++++++++++++++
 tb/tb_vga_framebuffer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_framebuffer.sv
// Cell framebuffer for the VGA output stage: FIFO-queued cell writes, 2-cycle pixel reads, clear FSM.
// Define FB_BOUNDS_CHECK_EN to drop out-of-range writes and raise the sticky err_oob flag.
module vga_framebuffer #(
  parameter int unsigned H_CELLS     = 160,
  parameter int unsigned V_CELLS     = 120,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned RGB_W       = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_x,
  input  logic [6:0]       wr_y,
  input  logic [RGB_W-1:0] wr_rgb,
  input  logic             clr_req,
  output logic             clr_busy,
  input  logic             rd_en,
  input  logic [9:0]       rd_px,
  input  logic [8:0]       rd_py,
  output logic [RGB_W-1:0] rd_rgb,
  output logic             err_oob
);

  localparam int unsigned CELLS = H_CELLS * V_CELLS;
  localparam int unsigned AW    = 15;
  localparam int unsigned PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned H_PX  = H_CELLS << SCALE_SHIFT;
  localparam int unsigned V_PX  = V_CELLS << SCALE_SHIFT;
  localparam logic [AW-1:0] LAST_ADDR = AW'(CELLS - 1);

  typedef enum logic {StIdle, StClear} state_e;

  state_e state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;

  logic [RGB_W-1:0] mem [CELLS];

  // Read pipeline
  logic             rd_en_q, rd_vld_q;
  logic [AW-1:0]    rd_addr_q, rd_addr_d;
  logic             rd_in_range;
  logic [RGB_W-1:0] rd_rgb_q;

  // Write FIFO
  logic [AW-1:0]    fifo_addr_q [FIFO_DEPTH];
  logic [RGB_W-1:0] fifo_rgb_q  [FIFO_DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [PW:0]      cnt_q;
  logic             full, empty, accept, push, pop, start_clr;
  logic [AW-1:0]    wr_addr;

  // Memory write port
  logic             clr_write, mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [RGB_W-1:0] mem_wdata;

  always_comb begin
    rd_in_range = (32'(rd_px) < H_PX) && (32'(rd_py) < V_PX);
    rd_addr_d   = AW'((32'(rd_py) >> SCALE_SHIFT) * H_CELLS + (32'(rd_px) >> SCALE_SHIFT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_rgb_q  <= '0;
    end else begin
      rd_en_q   <= rd_en;
      rd_vld_q  <= rd_en && rd_in_range;
      rd_addr_q <= rd_addr_d;
      rd_rgb_q  <= rd_vld_q ? mem[rd_addr_q] : '0;
    end
  end

  assign rd_rgb = rd_rgb_q;

  // A request arriving with clr_req is refused so the flush cannot lose an acknowledged write.
  assign full      = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign empty     = (cnt_q == '0);
  assign wr_ready  = !full && (state_q == StIdle) && !clr_req;
  assign accept    = wr_valid && wr_ready;
  assign wr_addr   = AW'(32'(wr_y) * H_CELLS + 32'(wr_x));
  assign pop       = !rd_en_q && (state_q == StIdle) && !empty;
  assign start_clr = (state_q == StIdle) && clr_req;
  assign clr_busy  = (state_q == StClear);

`ifdef FB_BOUNDS_CHECK_EN
  logic wr_in_range, err_oob_q;

  assign wr_in_range = (32'(wr_x) < H_CELLS) && (32'(wr_y) < V_CELLS);
  assign push        = accept && wr_in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_oob_q <= 1'b0;
    end else if (accept && !wr_in_range) begin
      err_oob_q <= 1'b1;
    end
  end

  assign err_oob = err_oob_q;
`else
  assign push    = accept;
  assign err_oob = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wptr_q] <= wr_addr;
      fifo_rgb_q[wptr_q]  <= wr_rgb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (start_clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Clear FSM: one cell per cycle the VGA stage leaves the port free.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (clr_req) begin
          state_d   = StClear;
          clr_cnt_d = '0;
        end
      end
      StClear: begin
        if (!rd_en_q) begin
          if (clr_cnt_q == LAST_ADDR) begin
            state_d   = StIdle;
            clr_cnt_d = '0;
          end else begin
            clr_cnt_d = clr_cnt_q + AW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign clr_write = (state_q == StClear) && !rd_en_q;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = fifo_addr_q[rptr_q];
    mem_wdata = fifo_rgb_q[rptr_q];
    if (clr_write) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
    end else if (pop) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_vga_framebuffer.sv
// Scoreboard bench for vga_framebuffer: stimulus pushes expectations, a monitor pops and compares.
// Honours FB_BOUNDS_CHECK_EN when the design is built with it.
module tb_vga_framebuffer;

  localparam int H     = 160;
  localparam int V     = 120;
  localparam int CELLS = H * V;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_x = '0;
  logic [6:0] wr_y = '0;
  logic [2:0] wr_rgb = '0;
  logic       clr_req = 1'b0;
  logic       clr_busy;
  logic       rd_en = 1'b0;
  logic [9:0] rd_px = '0;
  logic [8:0] rd_py = '0;
  logic [2:0] rd_rgb;
  logic       err_oob;

  vga_framebuffer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_x     (wr_x),
    .wr_y     (wr_y),
    .wr_rgb   (wr_rgb),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .rd_en    (rd_en),
    .rd_px    (rd_px),
    .rd_py    (rd_py),
    .rd_rgb   (rd_rgb),
    .err_oob  (err_oob)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int val;
    int px;
    int py;
  } exp_t;

  typedef struct {
    string name;
    int    act;
    int    exp;
  } dchk_t;

  exp_t  exp_q[$];
  dchk_t dchk_q[$];
  exp_t  e;
  dchk_t d;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_mem[CELLS];
  bit exp_oob = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: a pixel shows the colour of the 4x4 cell it falls in, black outside 640x480.
  function automatic int model_rd(bit en, int px, int py);
    if (!en || px >= H * 4 || py >= V * 4) return 0;
    return model_mem[(py / 4) * H + (px / 4)];
  endfunction

  function automatic void model_write(int x, int y, int rgb);
    int a;
    a = y * H + x;
`ifdef FB_BOUNDS_CHECK_EN
    if (x < H && y < V) model_mem[a] = rgb;
    else exp_oob = 1'b1;
`else
    if (a < CELLS) model_mem[a] = rgb;
`endif
  endfunction

  // Monitor: sole owner of the check counters.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (e.due != cyc || int'(rd_rgb) != e.val) begin
        errors++;
        $display("FAIL rd_rgb px=%0d py=%0d due=%0d at=%0d: got %0d expected %0d",
                 e.px, e.py, e.due, cyc, rd_rgb, e.val);
      end
    end
    while (dchk_q.size() > 0) begin
      d = dchk_q.pop_front();
      checks++;
      if (d.act != d.exp) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d", d.name, d.act, d.exp);
      end
    end
  end

  task automatic expect_eq(input string name, input int act, input int exp);
    dchk_q.push_back('{name: name, act: act, exp: exp});
  endtask

  task automatic tick();
    exp_q.push_back('{due: cyc + 2, val: model_rd(rd_en, int'(rd_px), int'(rd_py)),
                      px: int'(rd_px), py: int'(rd_py)});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    rd_en = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wr(input int x, input int y, input int rgb);
    int n;
    n = 0;
    wr_valid = 1'b1;
    wr_x = 8'(x);
    wr_y = 7'(y);
    wr_rgb = 3'(rgb);
    while (!wr_ready && n < 100) begin
      tick();
      n++;
    end
    expect_eq("wr_accept", int'(wr_ready), 1);
    if (wr_ready) model_write(x, y, rgb);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic rd_pix(input int px, input int py);
    rd_en = 1'b1;
    rd_px = 10'(px);
    rd_py = 9'(py);
    tick();
  endtask

  task automatic rd_cell(input int x, input int y);
    rd_pix(x * 4 + $urandom_range(0, 3), y * 4 + $urandom_range(0, 3));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy, stall_bad, n, x, y;

    // Reset values
    repeat (3) @(negedge clk);
    expect_eq("rst_rd_rgb", int'(rd_rgb), 0);
    expect_eq("rst_wr_ready", int'(wr_ready), 1);
    expect_eq("rst_clr_busy", int'(clr_busy), 0);
    expect_eq("rst_err_oob", int'(err_oob), 0);
    rst_n = 1'b1;
    idle(2);

    // Full clear; a write colliding with clr_req and writes during the clear must not land
    wr_valid = 1'b1;
    wr_x = 8'd1;
    wr_y = 7'd1;
    wr_rgb = 3'd7;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    busy = 0;
    stall_bad = 0;
    while (clr_busy && busy < 30000) begin
      if (wr_ready) stall_bad++;
      busy++;
      tick();
    end
    wr_valid = 1'b0;
    expect_eq("clr_busy_cycles", busy, CELLS);
    expect_eq("wr_stalled_in_clear", stall_bad, 0);
    expect_eq("wr_ready_after_clear", int'(wr_ready), 1);
    for (int i = 0; i < CELLS; i++) model_mem[i] = 0;
    idle(6);
    for (int yy = 0; yy < V; yy++)
      for (int xx = 0; xx < H; xx++) rd_cell(xx, yy);
    idle(3);

    // Directed write and 4x4 readback, plus neighbours
    wr(5, 3, 5);
    idle(8);
    for (int py = 12; py < 16; py++)
      for (int px = 20; px < 24; px++) rd_pix(px, py);
    rd_pix(24, 12);
    rd_pix(19, 15);
    rd_pix(20, 16);
    idle(3);

    // FIFO fill while the VGA stage owns the port; pixel 700 is off-screen
    rd_en = 1'b1;
    rd_px = 10'd700;
    rd_py = 9'd0;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_x = 8'(10 + (i == 0 ? 0 : i - 1));
      wr_y = 7'd10;
      wr_rgb = 3'(i + 1);
      expect_eq("wr_ready_fill", int'(wr_ready), 1);
      if (wr_ready) model_write(int'(wr_x), 10, i + 1);
      tick();
    end
    wr_x = 8'd13;
    wr_rgb = 3'd6;
    expect_eq("wr_ready_full", int'(wr_ready), 0);
    tick();
    tick();
    expect_eq("wr_ready_full_hold", int'(wr_ready), 0);
    rd_en = 1'b0;
    n = 0;
    while (!wr_ready && n < 20) begin
      tick();
      n++;
    end
    expect_eq("wr_ready_after_pop", int'(wr_ready), 1);
    expect_eq("first_pop_prompt", int'(n <= 3), 1);
    if (wr_ready) model_write(13, 10, 6);
    tick();
    wr_valid = 1'b0;
    idle(8);
    for (int xx = 10; xx < 14; xx++) rd_cell(xx, 10);
    idle(3);

    // Out-of-range write: dropped with err_oob, or aliased without the check
    wr(200, 3, 3);
    idle(8);
    rd_cell(40, 4);
    rd_cell(5, 3);
    idle(3);
    expect_eq("err_oob", int'(err_oob), int'(exp_oob));

    // Randomized writes then randomized reads
    repeat (200) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      wr($urandom_range(0, H - 1), $urandom_range(0, V - 1), $urandom_range(0, 7));
    end
    idle(8);
    repeat (400) begin
      rd_en = ($urandom_range(0, 3) != 0);
      rd_px = 10'($urandom_range(0, 700));
      rd_py = 9'($urandom_range(0, 511));
      tick();
    end
    idle(3);

    // Reset mid-clear at counter 1000: cells 0..999 cleared, 1000 onwards untouched
    wr(39, 6, 6);
    wr(40, 6, 7);
    idle(8);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (1000) tick();
    rst_n = 1'b0;
    #1;
    expect_eq("midclr_clr_busy", int'(clr_busy), 0);
    expect_eq("midclr_wr_ready", int'(wr_ready), 1);
    expect_eq("midclr_rd_rgb", int'(rd_rgb), 0);
    for (int i = 0; i < 1000; i++) model_mem[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    rd_cell(39, 6);
    rd_cell(40, 6);
    repeat (40) begin
      x = $urandom_range(0, H - 1);
      y = $urandom_range(0, 12);
      rd_cell(x, y);
    end
    idle(3);

    repeat (3) @(negedge clk);
    expect_eq("scoreboard_drained", exp_q.size(), 0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
